// File: rtl/hex_share_arbiter_if.sv
// hex_share_arbiter_if
// Bundles the request/value inputs and the grant/display outputs of the
// shared HEX digit arbiter.
//   req  : per-requester level request (bit i = requester i)
//   vals : packed 2-bit values, requester i owns vals[2i+1:2i]
//   gnt  : one-hot registered grant, zero when idle
//   ack  : one-cycle pulse to the granted requester in its last display cycle
//   hex  : active-low segment pattern {g,f,e,d,c,b,a}
//   busy : high while a grant is active
// The master modport is the requester side; the slave modport is the arbiter.
interface hex_share_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]   req;
    logic [2*N_REQ-1:0] vals;
    logic [N_REQ-1:0]   gnt;
    logic [N_REQ-1:0]   ack;
    logic [6:0]         hex;
    logic               busy;

    modport master (
        output req,
        output vals,
        input  gnt,
        input  ack,
        input  hex,
        input  busy
    );

    modport slave (
        input  req,
        input  vals,
        output gnt,
        output ack,
        output hex,
        output busy
    );
endinterface

// File: rtl/hex_share_arbiter.sv
// hex_share_arbiter
// Round-robin scheduler sharing one 7-segment HEX digit among N_REQ
// requesters. A granted requester's 2-bit value is latched and shown for
// DWELL cycles, the requester is acknowledged in the final cycle, and one
// blank cycle follows before the next arbitration.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : hex_share_arbiter_if slave modport (req, vals, gnt, ack, hex, busy)
module hex_share_arbiter #(
    parameter int N_REQ = 4,
    parameter int DWELL = 8
) (
    input  logic                clk,
    input  logic                reset,
    hex_share_arbiter_if.slave  bus
);
    localparam int CW = $clog2(DWELL + 1);
    localparam int LW = $clog2(N_REQ);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SHOW = 1'b1;

    logic [0:0]       state;
    logic [CW-1:0]    cnt;
    logic [LW-1:0]    last;
    logic [LW-1:0]    sel;
    logic             found;
    logic [1:0]       val_q;
    logic [N_REQ-1:0] gnt_q;
    logic [6:0]       hex_d;

    // Walk offsets from farthest to nearest so the nearest set request
    // after 'last' (wrapping) overwrites the others and wins.
    always_comb begin
        int idx;
        idx   = 0;
        sel   = last;
        found = 1'b0;
        for (int off = N_REQ; off >= 1; off--) begin
            idx = int'(last) + off;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (bus.req[idx]) begin
                sel   = LW'(idx);
                found = 1'b1;
            end
        end
    end

    // Reset makes requester 0 the first choice by parking 'last' on the top
    // index; an interrupted grant is simply forgotten.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            last  <= LW'(N_REQ - 1);
            val_q <= '0;
            gnt_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state <= SHOW;
                        gnt_q <= {{(N_REQ-1){1'b0}}, 1'b1} << sel;
                        last  <= sel;
                        val_q <= bus.vals[{sel, 1'b0} +: 2];
                        cnt   <= CW'(DWELL - 1);
                    end
                end
                SHOW: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                        gnt_q <= '0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Segment patterns match the team's 7-segment-to-value decoder.
    always_comb begin
        hex_d = 7'b1111111;
        if (state == SHOW) begin
            case (val_q)
                2'd0:    hex_d = 7'b1000000;
                2'd1:    hex_d = 7'b1111001;
                2'd2:    hex_d = 7'b0100100;
                default: hex_d = 7'b0110000;
            endcase
        end
    end

    assign bus.hex  = hex_d;
    assign bus.gnt  = gnt_q;
    assign bus.busy = (state == SHOW);
    assign bus.ack  = (state == SHOW && cnt == '0) ? gnt_q : '0;
endmodule

// File: tb/tb_hex_share_arbiter.sv
// tb_hex_share_arbiter
// Directed stimulus for hex_share_arbiter (N_REQ=4, DWELL=8). Expected
// grants are queued as stimulus is applied; a negedge monitor pops one entry
// per grant and checks grant, pattern, stability, ack timing and idle gap.
module tb_hex_share_arbiter;
    localparam int N_REQ = 4;
    localparam int DWELL = 8;

    typedef struct {
        logic [3:0] gnt;
        logic [6:0] hex;
        bit         aborted;
        int         gap;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    exp_t sb[$];

    hex_share_arbiter_if #(.N_REQ(N_REQ)) bus ();

    hex_share_arbiter #(.N_REQ(N_REQ), .DWELL(DWELL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for both the stimulus and monitor processes.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic [7:0] v);
        bus.req  = r;
        bus.vals = v;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pushExp(input logic [3:0] g, input logic [6:0] h,
                           input bit ab, input int gap);
        exp_t e;
        e.gnt = g;
        e.hex = h;
        e.aborted = ab;
        e.gap = gap;
        sb.push_back(e);
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_hex"},  32'(bus.hex),  32'h7f);
        checkOutput({tag, "_gnt"},  32'(bus.gnt),  32'h0);
        checkOutput({tag, "_ack"},  32'(bus.ack),  32'h0);
        checkOutput({tag, "_busy"}, 32'(bus.busy), 32'h0);
    endtask

    // Monitor: one scoreboard entry per grant, checked over its whole dwell.
    exp_t cur;
    bit   in_show = 0;
    bit   ack_seen = 0;
    int   show_cycles = 0;
    int   idle_gap = 0;

    always @(negedge clk) begin
        if (bus.busy) begin
            if (!in_show) begin
                in_show = 1;
                ack_seen = 0;
                show_cycles = 1;
                if (sb.size() == 0) begin
                    checkOutput("unexpected_grant", 32'(bus.gnt), 32'h0);
                    cur.gnt = bus.gnt;
                    cur.hex = bus.hex;
                    cur.aborted = 0;
                    cur.gap = -1;
                end else begin
                    cur = sb.pop_front();
                    checkOutput("grant", 32'(bus.gnt), 32'(cur.gnt));
                    checkOutput("grant_hex", 32'(bus.hex), 32'(cur.hex));
                    if (cur.gap >= 0)
                        checkOutput("idle_gap", 32'(idle_gap), 32'(cur.gap));
                end
            end else begin
                show_cycles++;
                checkOutput("gnt_stable", 32'(bus.gnt), 32'(cur.gnt));
                checkOutput("hex_stable", 32'(bus.hex), 32'(cur.hex));
            end
            if (bus.ack != '0) begin
                ack_seen = 1;
                checkOutput("ack_target", 32'(bus.ack), 32'(cur.gnt));
                checkOutput("ack_cycle", 32'(show_cycles), 32'(DWELL));
                checkOutput("ack_on_aborted", 32'(cur.aborted), 32'h0);
            end
        end else begin
            if (in_show) begin
                in_show = 0;
                checkOutput("ack_seen", 32'(ack_seen), 32'(!cur.aborted));
                idle_gap = 0;
            end
            idle_gap++;
            checkOutput("idle_ack", 32'(bus.ack), 32'h0);
            checkOutput("idle_hex", 32'(bus.hex), 32'h7f);
        end
    end

    initial begin
        checks = 0;
        failures = 0;

        // Reset held with every requester asking: display stays blank.
        reset = 1'b1;
        applyStimulus(4'b1111, 8'b11_10_01_00);
        repeat (4) begin
            @(posedge clk);
            #1;
            checkIdleOutputs("reset");
        end

        // Full contention straight out of reset: 0,1,2,3,0 with one blank
        // cycle between grants; req dropped during the fifth grant.
        pushExp(4'b0001, 7'b1000000, 0, -1);
        pushExp(4'b0010, 7'b1111001, 0, 1);
        pushExp(4'b0100, 7'b0100100, 0, 1);
        pushExp(4'b1000, 7'b0110000, 0, 1);
        pushExp(4'b0001, 7'b1000000, 0, 1);
        reset = 1'b0;
        tick(1);
        checkOutput("first_grant", 32'(bus.gnt), 32'h1);
        tick(38);
        applyStimulus(4'b0000, 8'b11_10_01_00);
        tick(10);

        // Single request from requester 2 with value 2.
        $display("[TB] single request");
        pushExp(4'b0100, 7'b0100100, 0, -1);
        applyStimulus(4'b0100, 8'b11_10_01_00);
        tick(2);
        applyStimulus(4'b0000, 8'b11_10_01_00);
        tick(10);

        // Fairness: requester 0 keeps requesting, 3 joins mid-dwell;
        // 3 must be served before 0 gets its second turn.
        $display("[TB] fairness");
        pushExp(4'b0001, 7'b1000000, 0, -1);
        pushExp(4'b1000, 7'b0110000, 0, 1);
        pushExp(4'b0001, 7'b1000000, 0, 1);
        applyStimulus(4'b0001, 8'b11_10_01_00);
        tick(1);
        tick(2);
        applyStimulus(4'b1001, 8'b11_10_01_00);
        tick(17);
        applyStimulus(4'b0000, 8'b11_10_01_00);
        tick(10);

        // Freeze and withdraw: value 1 latched, then vals and req change.
        $display("[TB] freeze and withdraw");
        pushExp(4'b0001, 7'b1111001, 0, -1);
        applyStimulus(4'b0001, 8'b11_10_01_01);
        tick(1);
        tick(2);
        applyStimulus(4'b0000, 8'b11_10_01_11);
        #1;
        checkOutput("frozen_hex", 32'(bus.hex), 32'h79);
        tick(10);

        // Reset in SHOW cycle 4 of requester 2's grant; afterwards
        // requester 2 (lowest pending) wins again, then 3.
        $display("[TB] async reset mid-show");
        pushExp(4'b0100, 7'b0100100, 1, -1);
        applyStimulus(4'b1100, 8'b11_10_01_00);
        tick(1);
        tick(3);
        reset = 1'b1;
        #1;
        checkIdleOutputs("async_reset");
        pushExp(4'b0100, 7'b0100100, 0, -1);
        pushExp(4'b1000, 7'b0110000, 0, 1);
        tick(2);
        checkIdleOutputs("reset_hold");
        reset = 1'b0;
        tick(1);
        checkOutput("post_reset_grant", 32'(bus.gnt), 32'h4);
        tick(11);
        applyStimulus(4'b0000, 8'b11_10_01_00);
        tick(12);

        checkOutput("sb_empty", 32'(sb.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/hex_share_arbiter.md
# hex_share_arbiter

Round-robin scheduler that shares a single 7-segment HEX digit among several requesters, each wanting to show a 2-bit value (0–3). The block grants one requester at a time and latches that requester's value. It drives the active-low segment pattern for a fixed dwell time, then acknowledges and re-arbitrates. It sits between game/control logic and a board HEX output. Its output patterns are the exact set consumed by the team's 7-segment-to-value decoder, so a decoder on the same bus recovers the granted value.

## Interface
- N_REQ, 4, number of requesters (2..8)
- DWELL, 8, cycles a granted value stays on the display (≥1)

- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high; forces reset state immediately
- req  input  N_REQ  per-requester level request; bit i = requester i
- vals  input  2*N_REQ  packed values; requester i owns vals[2i+1:2i]
- gnt  output  N_REQ  one-hot grant, registered; all-zero when idle
- ack  output  N_REQ  one-cycle pulse to the granted requester in its final display cycle
- hex  output  7  active-low segment pattern {g,f,e,d,c,b,a}
- busy  output  1  high while a grant is active

## Operation
- Two states, IDLE and SHOW. Dwell counter width is $clog2(DWELL+1). Round-robin pointer `last` holds the index of the most recently granted requester.
- IDLE:
  - hex = 7'b1111111 (blank), gnt = 0, busy = 0.
  - If any req bit is set, select the first set bit searching upward from last+1 and wrapping mod N_REQ.
  - On the next edge: enter SHOW, gnt = onehot(sel), last = sel, latch vals for sel into a 2-bit register, counter = DWELL-1.
- SHOW:
  - busy = 1. hex is the encoding of the latched value: 0→7'b1000000, 1→7'b1111001, 2→7'b0100100, 3→7'b0110000.
  - Counter decrements each cycle.
  - When counter == 0, ack = gnt for that cycle. The next edge returns to IDLE and clears gnt.
- Latched value is frozen: changes on vals during SHOW are ignored.
- Dropping req during SHOW does not abort. The dwell completes and ack is still pulsed.
- A requester still holding req after its ack is re-eligible. It is served only after every other pending requester, because of the round-robin order.
- Reset state: IDLE, gnt = 0, ack = 0, busy = 0, hex = 7'b1111111, counter = 0, last = N_REQ-1, so requester 0 has first priority.

## Timing
- Grant latency: req sampled high in IDLE at edge k → gnt/busy/hex valid after edge k. One cycle, no combinational req→gnt path.
- SHOW lasts exactly DWELL cycles. ack is high in the DWELL-th SHOW cycle only.
- Exactly one blank IDLE cycle separates consecutive grants. Continuous service period per request is DWELL+1 cycles.
- DWELL = 1: a single SHOW cycle with ack high.
- All outputs are registered or decoded from registered state only; there is no input→output combinational path.
- Reset asserted mid-SHOW:
  - Outputs go to reset values asynchronously, with no ack pulse.
  - The interrupted requester is not remembered.
  - After reset deasserts, arbitration restarts with requester 0 priority.
- Simultaneous requests are resolved only by the round-robin order, never by value.

## Test plan
- Reset: assert reset with req = 4'b1111 → hex = 7'b1111111, gnt = 0, ack = 0, busy = 0 throughout. Release reset → first grant goes to requester 0 one cycle later.
- Single request (DWELL = 8): req = 4'b0100, vals[5:4] = 2'b10 → gnt = 4'b0100 and hex = 7'b0100100 for 8 cycles. ack[2] is high in the 8th cycle only, then one blank cycle.
- Full contention: req = 4'b1111 held, vals = {3,2,1,0} → grants in order 0,1,2,3,0 every 9 cycles. hex cycles 1000000, 1111001, 0100100, 0110000 with a blank between each.
- Fairness: requester 0 re-requests immediately after its ack while req[3] is also high → requester 3 is granted before requester 0.
- Freeze and withdraw: change vals[1:0] and drop req[0] mid-SHOW → hex is unchanged and ack[0] still pulses at dwell end.
- Async reset at SHOW cycle 4 → immediate blank with gnt = 0 and no ack. The next grant goes to the lowest-index pending requester.
